twos_complement_unit: RTL and testbench
=======================================

Name: twos_complement_unit

Overview:
- Registered 20-bit negation unit that produces the two's complement (-a) of its operand. The datapath subtractor uses it to form the negated subtrahend (a - b = a + (-b)).
- It also supports ones'-complement and pass-through modes, and flags the zero and most-negative corner cases.
- Single-cycle latency, valid-qualified, with no backpressure.

Parameters:
- WIDTH, 20, operand/result bit width (must be >= 2)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand/mode valid this cycle
- mode  input  2  00 = two's complement (-a), 01 = ones' complement (~a), 10 = pass (a), 11 = reserved (treated as 00)
- a  input  WIDTH  operand, two's-complement signed
- out_valid  output  1  result valid (in_valid delayed one cycle)
- out  output  WIDTH  result
- zero  output  1  out == 0
- ovf  output  1  two's-complement overflow: mode 00/11 with a == 100…0 (most negative)

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low. While rst_n = 0: out_valid = 0, out = 0, zero = 0, ovf = 0, regardless of clk.
- Combinational core:
  - inv = ~a
  - neg = inv + 1, computed as a WIDTH-bit ripple-carry increment; the carry out of the MSB is discarded.
  - Result select by mode:
    - 00/11 -> neg
    - 01 -> inv
    - 10 -> a
- Registering: on each rising clk with rst_n = 1:
  - out_valid <= in_valid.
  - If in_valid = 1: out <= selected result; zero <= (selected result == 0); ovf <= (mode is 00 or 11) and (a == {1'b1, {WIDTH-1{1'b0}}}).
  - If in_valid = 0: out, zero and ovf hold their previous values.
- Latency: exactly 1 cycle from in_valid to out_valid. Throughput is one operand per cycle, back-to-back.
- Arithmetic rules:
  - -0 = 0 (the increment carry out is dropped).
  - -(most negative) = most negative, with ovf = 1.
  - For every other a, out + a = 0 mod 2^WIDTH.
- zero in mode 01 is 1 only when a is all-ones.
- ovf is 0 in modes 01 and 10.
- Reset mid-stream: asserting rst_n = 0 immediately clears all outputs and drops any in-flight result. The first valid output after release requires a new in_valid sampled at a clk edge with rst_n = 1.
- No X propagation from mode 11; it is functionally identical to mode 00.

Test Plan:
- Reset asserted asynchronously between edges -> out_valid = 0, out = 0x00000, zero = 0, ovf = 0 immediately.
- Mode 00 back-to-back, a = 0x00000, 0x7FFFF, 0xFFFFF, 0x55555 -> one cycle later each, out = 0x00000 (zero = 1), 0x80001, 0x00001, 0xAAAAB; ovf = 0 for all.
- Mode 00, a = 0x80000 -> out = 0x80000, ovf = 1, zero = 0. Mode 11 with the same a -> same result.
- Mode 01, a = 0xFFFFF -> out = 0x00000, zero = 1, ovf = 0. Mode 01, a = 0x55555 -> out = 0xAAAAA.
- Mode 10, a = 0x12345 -> out = 0x12345. Then in_valid = 0 with a changing -> out holds 0x12345 and out_valid = 0.
- Random sweep, 1000 operands in mode 00 -> (out + a) mod 2^20 = 0 for every a except 0x80000, which must produce ovf = 1.

Source files
------------

// File: rtl/twos_complement_unit_if.sv
// Operand/result bundle for the registered negation unit.
// The master drives the operand and mode; the slave returns the registered
// result together with its zero and overflow flags.
interface twos_complement_unit_if #(
  parameter int WIDTH = 20
);
  logic             in_valid;
  logic [1:0]       mode;
  logic [WIDTH-1:0] a;
  logic             out_valid;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid,
    output mode,
    output a,
    input  out_valid,
    input  out,
    input  zero,
    input  ovf
  );

  modport slave (
    input  in_valid,
    input  mode,
    input  a,
    output out_valid,
    output out,
    output zero,
    output ovf
  );
endinterface

// File: rtl/twos_complement_unit.sv
// Registered negation unit: two's complement, ones' complement or pass-through
// of a signed operand, with zero and most-negative overflow flags.
// One cycle latency, one operand per cycle, no backpressure.
module twos_complement_unit #(
  parameter int WIDTH = 20
) (
  input  logic                         clk,
  input  logic                         rst_n,
  twos_complement_unit_if.slave        bus
);

  typedef enum logic [1:0] {
    MODE_NEG  = 2'b00,
    MODE_INV  = 2'b01,
    MODE_PASS = 2'b10,
    MODE_RSVD = 2'b11
  } mode_t;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] inv;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] neg;
  logic [WIDTH-1:0] result;
  logic             result_zero;
  logic             result_ovf;
  logic             neg_mode;
  mode_t            mode_sel;

  assign mode_sel = mode_t'(bus.mode);

  // Ripple-carry increment of ~a; the carry out of the MSB is never formed,
  // which is what makes -0 wrap back to 0.
  always_comb begin
    inv      = ~bus.a;
    carry    = '0;
    carry[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      carry[i] = inv[i-1] & carry[i-1];
    end
    neg = inv ^ carry;
  end

  // Result select; the reserved mode aliases negation so it never yields X.
  always_comb begin
    result   = neg;
    neg_mode = 1'b1;
    case (mode_sel)
      MODE_NEG:  begin result = neg;   neg_mode = 1'b1; end
      MODE_INV:  begin result = inv;   neg_mode = 1'b0; end
      MODE_PASS: begin result = bus.a; neg_mode = 1'b0; end
      MODE_RSVD: begin result = neg;   neg_mode = 1'b1; end
      default:   begin result = neg;   neg_mode = 1'b1; end
    endcase
    result_zero = (result == '0);
    result_ovf  = neg_mode && (bus.a == MOST_NEG);
  end

  // Valid tracks in_valid every cycle; data and flags only load on a valid
  // operand so the last result stays visible between transactions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out       <= '0;
      bus.zero      <= 1'b0;
      bus.ovf       <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.out  <= result;
        bus.zero <= result_zero;
        bus.ovf  <= result_ovf;
      end
    end
  end

endmodule

// File: tb/tb_twos_complement_unit.sv
// Directed and sweep bench for the registered negation unit.
module tb_twos_complement_unit;
  localparam int WIDTH = 20;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  twos_complement_unit_if #(.WIDTH(WIDTH)) bus ();

  twos_complement_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset asserted between edges after a valid result was loaded.
  task automatic test_reset();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.mode = 2'b10; bus.a = 20'h12345;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out !== 20'h00000 || bus.zero !== 1'b0 || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got v=%b out=%h z=%b o=%b, want v=0 out=00000 z=0 o=0",
               bus.out_valid, bus.out, bus.zero, bus.ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out !== 20'h00000) begin
      errors++;
      $display("FAIL reset_release: got v=%b out=%h, want v=0 out=00000", bus.out_valid, bus.out);
    end
  endtask

  task automatic test_neg_back_to_back();
    logic [WIDTH-1:0] vin [4]  = '{20'h00000, 20'h7FFFF, 20'hFFFFF, 20'h55555};
    logic [WIDTH-1:0] vexp [4] = '{20'h00000, 20'h80001, 20'h00001, 20'hAAAAB};
    logic             zexp [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.mode = 2'b00; bus.a = vin[i];
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out !== vexp[i] || bus.zero !== zexp[i] || bus.ovf !== 1'b0) begin
        errors++;
        $display("FAIL neg_b2b[%0d]: got v=%b out=%h z=%b o=%b, want v=1 out=%h z=%b o=0",
                 i, bus.out_valid, bus.out, bus.zero, bus.ovf, vexp[i], zexp[i]);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_most_negative();
    logic [1:0] modes [2] = '{2'b00, 2'b11};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.mode = modes[i]; bus.a = 20'h80000;
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out !== 20'h80000 || bus.zero !== 1'b0 || bus.ovf !== 1'b1) begin
        errors++;
        $display("FAIL most_neg mode=%b: got v=%b out=%h z=%b o=%b, want v=1 out=80000 z=0 o=1",
                 modes[i], bus.out_valid, bus.out, bus.zero, bus.ovf);
      end
    end
    // Mode 11 on an ordinary operand must negate like mode 00.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.mode = 2'b11; bus.a = 20'h00003;
    @(posedge clk); #1;
    checks++;
    if (bus.out !== 20'hFFFFD || bus.ovf !== 1'b0 || bus.zero !== 1'b0) begin
      errors++;
      $display("FAIL rsvd_neg: got out=%h z=%b o=%b, want out=FFFFD z=0 o=0", bus.out, bus.zero, bus.ovf);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_ones();
    logic [WIDTH-1:0] vin [3]  = '{20'hFFFFF, 20'h55555, 20'h80000};
    logic [WIDTH-1:0] vexp [3] = '{20'h00000, 20'hAAAAA, 20'h7FFFF};
    logic             zexp [3] = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.mode = 2'b01; bus.a = vin[i];
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out !== vexp[i] || bus.zero !== zexp[i] || bus.ovf !== 1'b0) begin
        errors++;
        $display("FAIL ones[%0d]: got v=%b out=%h z=%b o=%b, want v=1 out=%h z=%b o=0",
                 i, bus.out_valid, bus.out, bus.zero, bus.ovf, vexp[i], zexp[i]);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_pass_hold();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.mode = 2'b10; bus.a = 20'h12345;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out !== 20'h12345 || bus.zero !== 1'b0 || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL pass: got v=%b out=%h z=%b o=%b, want v=1 out=12345 z=0 o=0",
               bus.out_valid, bus.out, bus.zero, bus.ovf);
    end
    // Pass of the most negative value must not flag overflow.
    @(negedge clk);
    bus.a = 20'h80000;
    @(posedge clk); #1;
    checks++;
    if (bus.out !== 20'h80000 || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL pass_mostneg: got out=%h o=%b, want out=80000 o=0", bus.out, bus.ovf);
    end
    @(negedge clk);
    bus.a = 20'h12345;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0; bus.mode = 2'b00; bus.a = 20'h00000 + 20'(i * 20'h11111);
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out !== 20'h12345 || bus.zero !== 1'b0 || bus.ovf !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d]: got v=%b out=%h z=%b o=%b, want v=0 out=12345 z=0 o=0",
                 i, bus.out_valid, bus.out, bus.zero, bus.ovf);
      end
    end
  endtask

  task automatic test_random_sweep();
    logic [WIDTH-1:0] av;
    logic [WIDTH-1:0] sum;
    int               bad;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (i == 500)      av = 20'h80000;
      else if (i == 250) av = 20'h00000;
      else               av = WIDTH'($urandom_range(0, 32'hFFFFF));
      bus.in_valid = 1'b1; bus.mode = 2'b00; bus.a = av;
      @(posedge clk); #1;
      sum = bus.out + av;
      checks++;
      if (av == 20'h80000) begin
        if (bus.out !== 20'h80000 || bus.ovf !== 1'b1 || bus.zero !== 1'b0 || bus.out_valid !== 1'b1) begin
          errors++; bad++;
          $display("FAIL sweep[%0d] a=%h: got out=%h o=%b z=%b v=%b, want out=80000 o=1 z=0 v=1",
                   i, av, bus.out, bus.ovf, bus.zero, bus.out_valid);
        end
      end else if (sum !== 20'h00000 || bus.ovf !== 1'b0 || bus.zero !== (av == 20'h00000)
                   || bus.out_valid !== 1'b1) begin
        errors++; bad++;
        if (bad < 10)
          $display("FAIL sweep[%0d] a=%h: got out=%h sum=%h o=%b z=%b v=%b, want sum=00000 o=0 z=%b v=1",
                   i, av, bus.out, sum, bus.ovf, bus.zero, bus.out_valid, (av == 20'h00000));
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // An operand presented just before reset must not emerge afterwards.
  task automatic test_reset_midstream();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.mode = 2'b00; bus.a = 20'h00005;
    #2;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out !== 20'h00000) begin
      errors++;
      $display("FAIL reset_mid: got v=%b out=%h, want v=0 out=00000", bus.out_valid, bus.out);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out !== 20'h00000 || bus.zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_release: got v=%b out=%h z=%b, want v=0 out=00000 z=0",
               bus.out_valid, bus.out, bus.zero);
    end
    @(negedge clk);
    bus.in_valid = 1'b1; bus.a = 20'h00005;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out !== 20'hFFFFB) begin
      errors++;
      $display("FAIL reset_mid_first: got v=%b out=%h, want v=1 out=FFFFB", bus.out_valid, bus.out);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.mode = 2'b00;
    bus.a = '0;
    #12;
    rst_n = 1'b1;
    test_reset();
    test_neg_back_to_back();
    test_most_negative();
    test_ones();
    test_pass_hold();
    test_random_sweep();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
